// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage pipeline: tracks in-flight destinations (EX, MEM)
// from ID fields, raises load-use / jr-operand stalls, and applies redirects.
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic             branch_taken,
  output logic             hazard,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [4:0] REG_RA  = 5'd31;

  typedef struct packed {
    logic       wr;
    logic [4:0] dst;
    logic       load;
  } sbEntry_t;

  sbEntry_t idEntry, exEntry, memEntry;
  logic isR, isShift, isJr, isJump, readsRs, readsRt;
  logic loadUse, jrDep, stall;

  // Decode the ID instruction into operand reads and a scoreboard entry
  always_comb begin
    isR     = (opcode == OP_R);
    isShift = isR & ((funct == F_SLL) | (funct == F_SRL) | (funct == F_SRA));
    isJr    = id_valid & isR & (funct == F_JR);
    isJump  = id_valid & ((opcode == OP_J) | (opcode == OP_JAL) | (isR & (funct == F_JR)));
    readsRs = id_valid & ~((opcode == OP_J) | (opcode == OP_JAL) | (opcode == OP_LUI) | isShift);
    readsRt = id_valid & (isR | (opcode == OP_BEQ) | (opcode == OP_BNE) | (opcode == OP_SW));
    idEntry = '0;
    case (opcode)
      OP_R: begin
        if (funct != F_JR) begin
          idEntry.wr  = 1'b1;
          idEntry.dst = rd;
        end
      end
      OP_ADDI, OP_ORI, OP_LUI, OP_LW: begin
        idEntry.wr  = 1'b1;
        idEntry.dst = rt;
      end
      OP_JAL: begin
        idEntry.wr  = 1'b1;
        idEntry.dst = REG_RA;
      end
      default: ;
    endcase
    idEntry.load = (opcode == OP_LW);
    // $0 and empty slots never act as producers
    if (!id_valid || idEntry.dst == 5'd0 || !idEntry.wr) idEntry = '0;
  end

  always_comb begin
    loadUse = exEntry.load & exEntry.wr &
              ((readsRs & (rs == exEntry.dst)) | (readsRt & (rt == exEntry.dst)));
    jrDep   = isJr & ((exEntry.wr & (rs == exEntry.dst)) |
                      (memEntry.load & memEntry.wr & (rs == memEntry.dst)));
    stall   = loadUse | jrDep;
  end

  // Redirect outranks stall; a taken branch squashes whatever sits in ID
  always_comb begin
    hazard     = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    if (branch_taken) begin
      hazard     = 1'b1;
      ifid_flush = 1'b1;
    end else if (stall) begin
      hazard     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (isJump) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exEntry   <= '0;
      memEntry  <= '0;
      stall_cnt <= '0;
    end else begin
      memEntry <= exEntry;
      exEntry  <= hazard ? '0 : idEntry;
      if (stall && !branch_taken && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, hand sequences for saturation and
// mid-stall reset, then random instructions against a distance-based model.
module tb_hazard_unit;
  localparam int unsigned CW = 4;

  logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, branch_taken = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic hazard, pc_write, ifid_write, ifid_flush;
  logic [CW-1:0] stall_cnt;
  int nCmp = 0, nFail = 0;

  hazard_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .branch_taken(branch_taken), .hazard(hazard),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .stall_cnt(stall_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit v; logic [5:0] op, fn; logic [4:0] s, t, d; bit bt;
    logic [3:0] exp; int cnt;  // exp = {hazard, pc_write, ifid_write, ifid_flush}
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(bit v, logic [5:0] op, logic [5:0] fn, logic [4:0] s,
                              logic [4:0] t, logic [4:0] d, bit bt, logic [3:0] e, int c);
    vec_t x;
    x.v = v; x.op = op; x.fn = fn; x.s = s; x.t = t; x.d = d; x.bt = bt; x.exp = e; x.cnt = c;
    return x;
  endfunction

  task automatic chk(string nm, int act, int exp);
    nCmp++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: producers remembered by how many slots ahead of ID they are (0 = next, 1 = after)
  typedef struct { bit w; bit [4:0] d; bit ld; } prod_t;
  prod_t fly[2];
  int mCnt;
  bit mHz, mPcw, mIfw, mFl, mStall;
  prod_t mDec;

  task automatic mReset();
    fly[0] = '{0, 0, 0}; fly[1] = '{0, 0, 0}; mCnt = 0;
  endtask

  task automatic mEval();
    bit jr, jmp, rdRs, rdRt, uses;
    jr   = id_valid && opcode == 6'h00 && funct == 6'h08;
    jmp  = jr || (id_valid && (opcode == 6'h02 || opcode == 6'h03));
    rdRs = id_valid && !(opcode inside {6'h02, 6'h03, 6'h0F} ||
                         (opcode == 6'h00 && funct inside {6'h00, 6'h02, 6'h03}));
    rdRt = id_valid && (opcode inside {6'h00, 6'h04, 6'h05, 6'h2B});
    mDec = '{0, 0, 0};
    if (id_valid) begin
      if (opcode == 6'h00 && !jr) mDec = '{1, rd, 0};
      else if (opcode inside {6'h08, 6'h0D, 6'h0F, 6'h23}) mDec = '{1, rt, opcode == 6'h23};
      else if (opcode == 6'h03) mDec = '{1, 5'd31, 0};
      if (mDec.d == 0) mDec = '{0, 0, 0};
    end
    mStall = 0;
    for (int k = 0; k < 2; k++) begin
      if (!fly[k].w) continue;
      uses = (rdRs && rs == fly[k].d) || (rdRt && rt == fly[k].d);
      if (fly[k].ld && k == 0 && uses) mStall = 1;         // load result one slot away
      if (jr && rs == fly[k].d && (k == 0 || fly[k].ld)) mStall = 1;
    end
    mHz = branch_taken || mStall;
    mPcw = branch_taken || !mStall;
    mIfw = mPcw;
    mFl = branch_taken || (!mStall && jmp);
  endtask

  task automatic mClock();
    if (mStall && !branch_taken && mCnt < (1 << CW) - 1) mCnt++;
    fly[1] = fly[0];
    fly[0] = mHz ? '{0, 0, 0} : mDec;
  endtask

  task automatic apply(bit v, logic [5:0] op, logic [5:0] fn, logic [4:0] s, logic [4:0] t,
                       logic [4:0] d, bit bt);
    id_valid = v; opcode = op; funct = fn; rs = s; rt = t; rd = d; branch_taken = bt;
  endtask

  task automatic chkModel(string tag);
    mEval();
    chk({tag, ".hazard"}, int'(hazard), int'(mHz));
    chk({tag, ".pc_write"}, int'(pc_write), int'(mPcw));
    chk({tag, ".ifid_write"}, int'(ifid_write), int'(mIfw));
    chk({tag, ".ifid_flush"}, int'(ifid_flush), int'(mFl));
    chk({tag, ".stall_cnt"}, int'(stall_cnt), mCnt);
  endtask

  task automatic endCycle();
    mClock();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0; id_valid = 1'b0; branch_taken = 1'b0;
    mReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [5:0] opList[10] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] fnList[6]  = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h25};
  logic [4:0] rgList[4]  = '{5'd0, 5'd8, 5'd9, 5'd31};

  initial begin
    vec_t x;
    //        v  op     fn     rs  rt  rd  bt  exp      cnt
    vt.push_back(mk(0, 6'h00, 6'h00, 0, 0, 0, 0, 4'b0110, 0));
    vt.push_back(mk(1, 6'h23, 6'h00, 16, 8, 0, 0, 4'b0110, 0));  // lw $8
    vt.push_back(mk(1, 6'h00, 6'h20, 8, 10, 9, 0, 4'b1000, 0));  // add uses $8
    vt.push_back(mk(1, 6'h00, 6'h20, 8, 10, 9, 0, 4'b0110, 1));
    vt.push_back(mk(1, 6'h23, 6'h00, 16, 8, 0, 0, 4'b0110, 1));
    vt.push_back(mk(1, 6'h2B, 6'h00, 16, 8, 0, 0, 4'b1000, 1));  // sw rt use
    vt.push_back(mk(1, 6'h2B, 6'h00, 16, 8, 0, 0, 4'b0110, 2));
    vt.push_back(mk(1, 6'h23, 6'h00, 16, 0, 0, 0, 4'b0110, 2));  // lw $0
    vt.push_back(mk(1, 6'h00, 6'h20, 0, 0, 9, 0, 4'b0110, 2));
    vt.push_back(mk(1, 6'h08, 6'h00, 0, 31, 0, 0, 4'b0110, 2));  // addi $ra
    vt.push_back(mk(1, 6'h00, 6'h08, 31, 0, 0, 0, 4'b1000, 2));  // jr $ra
    vt.push_back(mk(1, 6'h00, 6'h08, 31, 0, 0, 0, 4'b0111, 3));
    vt.push_back(mk(1, 6'h23, 6'h00, 16, 31, 0, 0, 4'b0110, 3)); // lw $ra
    vt.push_back(mk(1, 6'h00, 6'h08, 31, 0, 0, 0, 4'b1000, 3));
    vt.push_back(mk(1, 6'h00, 6'h08, 31, 0, 0, 0, 4'b1000, 4));
    vt.push_back(mk(1, 6'h00, 6'h08, 31, 0, 0, 0, 4'b0111, 5));
    vt.push_back(mk(1, 6'h23, 6'h00, 16, 8, 0, 0, 4'b0110, 5));
    vt.push_back(mk(1, 6'h00, 6'h20, 8, 10, 9, 1, 4'b1111, 5));  // branch beats stall
    vt.push_back(mk(1, 6'h00, 6'h20, 8, 10, 9, 0, 4'b0110, 5));  // EX held a bubble
    vt.push_back(mk(1, 6'h23, 6'h00, 16, 8, 0, 0, 4'b0110, 5));
    vt.push_back(mk(0, 6'h00, 6'h20, 8, 10, 9, 0, 4'b0110, 5));  // invalid consumer
    vt.push_back(mk(1, 6'h00, 6'h20, 8, 10, 9, 0, 4'b0110, 5));
    vt.push_back(mk(0, 6'h23, 6'h00, 16, 8, 0, 0, 4'b0110, 5));  // invalid producer
    vt.push_back(mk(1, 6'h00, 6'h20, 8, 10, 9, 0, 4'b0110, 5));
    vt.push_back(mk(1, 6'h02, 6'h00, 0, 0, 0, 0, 4'b0111, 5));   // j
    vt.push_back(mk(1, 6'h03, 6'h00, 0, 0, 0, 0, 4'b0111, 5));   // jal
    vt.push_back(mk(1, 6'h00, 6'h08, 31, 0, 0, 0, 4'b1000, 5));  // jr behind jal
    vt.push_back(mk(1, 6'h00, 6'h08, 31, 0, 0, 0, 4'b0111, 6));

    mReset();
    #2;
    chk("rst.hazard", int'(hazard), 0);
    chk("rst.pc_write", int'(pc_write), 1);
    chk("rst.ifid_write", int'(ifid_write), 1);
    chk("rst.ifid_flush", int'(ifid_flush), 0);
    chk("rst.stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      x = vt[i];
      apply(x.v, x.op, x.fn, x.s, x.t, x.d, x.bt);
      #1;
      mEval();
      chk($sformatf("v%0d.hazard", i), int'(hazard), int'(x.exp[3]));
      chk($sformatf("v%0d.pc_write", i), int'(pc_write), int'(x.exp[2]));
      chk($sformatf("v%0d.ifid_write", i), int'(ifid_write), int'(x.exp[1]));
      chk($sformatf("v%0d.ifid_flush", i), int'(ifid_flush), int'(x.exp[0]));
      chk($sformatf("v%0d.stall_cnt", i), int'(stall_cnt), x.cnt);
      endCycle();
    end

    // Saturation: 2^CW+3 load-use stalls
    doReset();
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      apply(1, 6'h23, 6'h00, 16, 8, 0, 0);
      #1; mEval(); endCycle();
      apply(1, 6'h00, 6'h20, 8, 10, 9, 0);
      #1; mEval(); endCycle();
    end
    apply(0, 6'h00, 6'h00, 0, 0, 0, 0);
    #1;
    chk("sat.stall_cnt", int'(stall_cnt), 15);
    endCycle();

    // Reset in the middle of a lw -> jr stall
    doReset();
    apply(1, 6'h23, 6'h00, 16, 31, 0, 0);
    #1; mEval(); endCycle();
    apply(1, 6'h00, 6'h08, 31, 0, 0, 0);
    #1;
    chk("mid.hazard_pre", int'(hazard), 1);
    rst_n = 1'b0;
    #1;
    chk("mid.hazard", int'(hazard), 0);
    chk("mid.pc_write", int'(pc_write), 1);
    chk("mid.ifid_write", int'(ifid_write), 1);
    chk("mid.ifid_flush_jr", int'(ifid_flush), 1);
    chk("mid.stall_cnt", int'(stall_cnt), 0);
    id_valid = 1'b0;
    #1;
    chk("mid.ifid_flush_idle", int'(ifid_flush), 0);
    mReset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 6'h00, 6'h08, 31, 0, 0, 0);
    #1;
    chk("post.hazard", int'(hazard), 0);
    chk("post.ifid_flush", int'(ifid_flush), 1);
    chk("post.pc_write", int'(pc_write), 1);
    mEval(); endCycle();

    // Random instruction stream against the model
    doReset();
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(9, 0) != 0, opList[$urandom_range(9, 0)], fnList[$urandom_range(5, 0)],
            rgList[$urandom_range(3, 0)], rgList[$urandom_range(3, 0)], rgList[$urandom_range(3, 0)],
            $urandom_range(9, 0) == 0);
      #1;
      chkModel($sformatf("rnd%0d", i));
      endCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
